mcp4921_rx: RTL

Frame receiver for the MCP4921 12-bit DAC SPI write protocol: it acts as the device end of the link that the `mcp4921` transmitter drives. It oversamples SPICLK, MOSI and CS in the system clock domain and decodes each 16-bit frame into its four configuration bits and 12-bit data word. Frames that are not exactly 16 bits long are flagged. It serves as a loopback checker for the DAC driver and as a bus monitor on boards that mirror the DAC bus into the FPGA.

---
 rtl/mcp4921_rx.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/mcp4921_rx.sv
// Device-side receiver for the MCP4921 SPI write frame: oversamples the bus in
// the CLK domain, decodes 16-bit frames and flags frames of any other length.
module mcp4921_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        i_SPICLK,
    input  logic        i_MOSI,
    input  logic        i_CS,
    output logic [11:0] o_data,
    output logic        o_ab,
    output logic        o_buf,
    output logic        o_gain_n,
    output logic        o_shdn_n,
    output logic        o_valid,
    output logic        o_err,
    output logic        o_busy,
    output logic [7:0]  o_frames
);

    typedef enum logic [1:0] {
        S_WAIT_IDLE = 2'd0,
        S_IDLE      = 2'd1,
        S_SHIFT     = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_d;
    logic                   r_cs_d;
    logic [SYNC_STAGES:0]   r_prime;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_shift;
    logic [15:0] w_shift_upd;
    logic [15:0] w_shift_nxt;
    logic [4:0]  r_cnt;
    logic [4:0]  w_cnt_upd;
    logic [4:0]  w_cnt_nxt;
    logic        w_load;
    logic        w_err;

    logic [11:0] r_data;
    logic        r_ab;
    logic        r_buf;
    logic        r_gain_n;
    logic        r_shdn_n;
    logic        r_valid;
    logic        r_err;
    logic        r_busy;
    logic [7:0]  r_frames;

    logic w_sclk;
    logic w_cs;
    logic w_mosi;
    logic w_sclk_rise;
    logic w_cs_fall;
    logic w_cs_rise;

    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs        = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk & ~r_sclk_d;
    assign w_cs_fall   = ~w_cs & r_cs_d;
    assign w_cs_rise   = w_cs & ~r_cs_d;

    // Input synchronizers, edge-detect flops and post-reset priming shifter.
    // r_prime keeps WAIT_IDLE from trusting the reset-preset CS chain, so a CS
    // held low through reset release is seen as low before IDLE is entered.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_sclk_sync <= '1;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b1;
            r_cs_d      <= 1'b1;
            r_prime     <= '0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_SPICLK};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_CS};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_MOSI};
            r_sclk_d    <= w_sclk;
            r_cs_d      <= w_cs;
            r_prime     <= {r_prime[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // Next-state and frame judgement; a bit arriving with CS rise is shifted first.
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        w_err       = 1'b0;
        w_shift_upd = r_shift;
        w_cnt_upd   = r_cnt;

        if (w_sclk_rise) begin
            w_shift_upd = {r_shift[14:0], w_mosi};
            w_cnt_upd   = (r_cnt == 5'd17) ? 5'd17 : (r_cnt + 5'd1);
        end else begin
            w_shift_upd = r_shift;
            w_cnt_upd   = r_cnt;
        end

        case (r_state)
            S_WAIT_IDLE: begin
                if (r_prime[SYNC_STAGES] && w_cs) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_WAIT_IDLE;
                end
            end
            S_IDLE: begin
                if (w_cs_fall) begin
                    w_shift_nxt = 16'h0000;
                    w_cnt_nxt   = 5'd0;
                    w_state_nxt = S_SHIFT;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SHIFT: begin
                w_shift_nxt = w_shift_upd;
                w_cnt_nxt   = w_cnt_upd;
                if (w_cs_rise) begin
                    w_state_nxt = S_IDLE;
                    if (w_cnt_upd == 5'd16) begin
                        w_load = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
                end else begin
                    w_state_nxt = S_SHIFT;
                end
            end
            default: begin
                w_state_nxt = S_WAIT_IDLE;
            end
        endcase
    end

    // State, shift register and registered outputs.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state  <= S_WAIT_IDLE;
            r_shift  <= 16'h0000;
            r_cnt    <= 5'd0;
            r_data   <= 12'h000;
            r_ab     <= 1'b0;
            r_buf    <= 1'b0;
            r_gain_n <= 1'b1;
            r_shdn_n <= 1'b0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
            r_busy   <= 1'b0;
            r_frames <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_cnt   <= w_cnt_nxt;
            r_valid <= w_load;
            r_err   <= w_err;
            r_busy  <= (w_state_nxt == S_SHIFT);
            if (w_load) begin
                r_ab     <= w_shift_upd[15];
                r_buf    <= w_shift_upd[14];
                r_gain_n <= w_shift_upd[13];
                r_shdn_n <= w_shift_upd[12];
                r_data   <= w_shift_upd[11:0];
                r_frames <= r_frames + 8'd1;
            end else begin
                r_ab     <= r_ab;
                r_buf    <= r_buf;
                r_gain_n <= r_gain_n;
                r_shdn_n <= r_shdn_n;
                r_data   <= r_data;
                r_frames <= r_frames;
            end
        end
    end

    assign o_data   = r_data;
    assign o_ab     = r_ab;
    assign o_buf    = r_buf;
    assign o_gain_n = r_gain_n;
    assign o_shdn_n = r_shdn_n;
    assign o_valid  = r_valid;
    assign o_err    = r_err;
    assign o_busy   = r_busy;
    assign o_frames = r_frames;

endmodule
